uart_xcvr: RTL
==============

UART_XCVR -- requirements
Module: uart_xcvr

Interface
REQ-001 SHALL have parameter CLOCKRATE, default 100000000, meaning system clock frequency in Hz.
REQ-002 SHALL have parameter BAUDRATE, default 9600, meaning line bit rate in baud.
REQ-003 SHALL have parameter DATA_BITS, default 8, meaning character length; legal range 5..9.
REQ-004 SHALL have parameter PARITY, default 1, meaning 0 = none, 1 = even, 2 = odd.
REQ-005 SHALL have parameter STOP_BITS, default 1, meaning stop bits; legal values 1 or 2.
REQ-006 SHALL have parameter FIFO_AW, default 5, meaning log2 of TX and RX FIFO depth each.
REQ-007 SHALL have port CLK, input, 1, meaning system clock; all logic on its rising edge.
REQ-008 SHALL have port RST, input, 1, meaning reset; asynchronous, active-high.
REQ-009 SHALL have port tx_valid, input, 1, meaning write request into TX FIFO.
REQ-010 SHALL have port tx_data, input, DATA_BITS, meaning character to send.
REQ-011 SHALL have port tx_ready, output, 1, meaning TX FIFO not full.
REQ-012 SHALL have port rx_ready, input, 1, meaning pop request from RX FIFO.
REQ-013 SHALL have port rx_valid, output, 1, meaning RX FIFO not empty.
REQ-014 SHALL have port rx_data, output, DATA_BITS, meaning head-of-FIFO character (show-ahead).
REQ-015 SHALL have port rx_perr, output, 1, meaning head character had a parity error.
REQ-016 SHALL have port rx_ferr, output, 1, meaning head character had a framing error.
REQ-017 SHALL have port overrun, output, 1, meaning sticky flag: character lost because RX FIFO was full.
REQ-018 SHALL have port ovr_clr, input, 1, meaning clears overrun.
REQ-019 SHALL have port tx_busy, output, 1, meaning serializer is not idle.
REQ-020 SHALL have port Tx, output, 1, meaning serial out; idles at 1.
REQ-021 SHALL have port Rx, input, 1, meaning asynchronous serial input.

Function
REQ-022 SHALL derive a 16x oversample tick every CLOCKRATE/(BAUDRATE*16) clocks from a free-running divider.
REQ-023 SHALL implement the handshakes fully synchronously: tx_valid&&tx_ready pushes one entry per cycle; rx_valid&&rx_ready pops one entry per cycle. Requests while full/empty SHALL be ignored with no state change.
REQ-024 SHALL pass Rx through a 2-flop synchronizer before any use.
REQ-025 SHALL use the RX FSM states IDLE -> START -> DATA -> PAR (only when PARITY != 0) -> STOP -> IDLE.
REQ-026 RX, IDLE: on a synchronized 1->0 transition, SHALL enter START with the tick counter cleared.
REQ-027 RX, START: at tick 8, if the line is still 0 SHALL go to DATA; otherwise SHALL return to IDLE (glitch reject), with nothing pushed.
REQ-028 RX, bit decision: each bit SHALL be the 2-of-3 majority of samples at ticks 7, 8 and 9 of its 16-tick period; data SHALL be received LSB first.
REQ-029 RX, parity: perr SHALL be set when the received parity bit differs from the even/odd parity computed over the data bits.
REQ-030 RX, STOP: only the first stop bit SHALL be checked; a 0 sets ferr. The character with its perr/ferr SHALL be pushed in the cycle of the stop decision, after which the FSM returns to IDLE.
REQ-031 RX, full FIFO: if the RX FIFO is full at push time, the character SHALL be dropped and overrun set. ovr_clr SHALL clear overrun, but a simultaneous new overrun SHALL win.
REQ-032 TX: when idle with the TX FIFO non-empty, on a baud boundary (every 16 ticks) the serializer SHALL pop one entry and drive, one bit per period: start 0, DATA_BITS LSB first, parity (if enabled), STOP_BITS 1s.
REQ-033 TX: tx_busy SHALL be 1 from the pop through the end of the last stop bit. Back-to-back characters SHALL leave no idle gap beyond the next baud boundary.
REQ-034 Each FIFO SHALL be 2^FIFO_AW entries with pointers one bit wider than the address; wrap-around SHALL be correct, and a simultaneous push and pop on a non-empty, non-full FIFO SHALL keep occupancy unchanged.

Reset
REQ-035 While RST is high: Tx=1, tx_ready=1, rx_valid=0, rx_data=0, rx_perr=0, rx_ferr=0, overrun=0, tx_busy=0, both FIFOs empty, both FSMs IDLE, all dividers 0.
REQ-036 Reset mid-character SHALL abort the character with no partial push, and Tx SHALL be 1 in the same cycle RST asserts.

Verification
REQ-037 Loopback Tx->Rx, defaults, send 0x55, 0xA3, 0x00 -> the same three characters pop in order with rx_perr=rx_ferr=0.
REQ-038 PARITY=2, a character 0x0F injected with wrong parity -> rx_data=0x0F with rx_perr=1, rx_ferr=0.
REQ-039 A stop bit driven 0 -> rx_ferr=1; a 0.25-bit low pulse on Rx -> nothing pushed.
REQ-040 FIFO_AW=2, 5 characters received with no pops -> 4 stored, overrun=1; ovr_clr -> 0.
REQ-041 DATA_BITS=7, STOP_BITS=2, PARITY=0, 0x41 written -> Tx waveform 0,1000001 (LSB first),1,1, then idle.
REQ-042 RST asserted mid-transmit -> Tx=1 immediately, tx_busy=0, tx_ready=1, and no RX push.

Source files
------------

// File: rtl/uart_xcvr.sv
// Buffered UART: TX/RX FIFOs around a 16x-oversampled receiver and a framed serializer.
// Frame format and bit rate are fixed at elaboration; FIFO requests while full/empty are dropped.
module uart_fifo #(
   parameter int W  = 8,
   parameter int AW = 5
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic         push,
   input  logic [W-1:0] push_data,
   input  logic         pop,
   output logic [W-1:0] head,
   output logic         full,
   output logic         empty
);
   logic [W-1:0] mem [2**AW];
   logic [AW:0]  wr_ptr;
   logic [AW:0]  rd_ptr;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign head  = empty ? '0 : mem[rd_ptr[AW-1:0]];

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push && !full)
            wr_ptr <= wr_ptr + (AW+1)'(1);
         if (pop && !empty)
            rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   always_ff @(posedge CLK) begin
      if (push && !full)
         mem[wr_ptr[AW-1:0]] <= push_data;
   end
endmodule

module uart_xcvr #(
   parameter int CLOCKRATE = 100000000,
   parameter int BAUDRATE  = 9600,
   parameter int DATA_BITS = 8,
   parameter int PARITY    = 1,
   parameter int STOP_BITS = 1,
   parameter int FIFO_AW   = 5
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 tx_valid,
   input  logic [DATA_BITS-1:0] tx_data,
   output logic                 tx_ready,
   input  logic                 rx_ready,
   output logic                 rx_valid,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_perr,
   output logic                 rx_ferr,
   output logic                 overrun,
   input  logic                 ovr_clr,
   output logic                 tx_busy,
   output logic                 Tx,
   input  logic                 Rx
);
   localparam int DIV_RAW = CLOCKRATE / (BAUDRATE * 16);
   localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
   localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int PB      = (PARITY != 0) ? 1 : 0;
   localparam int FW      = 1 + DATA_BITS + PB + STOP_BITS;

   typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP} rx_state_t;
   typedef enum logic {TX_IDLE, TX_SEND} tx_state_t;

   // oversample tick
   logic [DW-1:0] div_cnt;
   logic          tick;
   assign tick = (div_cnt == DW'(DIV - 1));

   always_ff @(posedge CLK or posedge RST) begin
      if (RST)       div_cnt <= '0;
      else if (tick) div_cnt <= '0;
      else           div_cnt <= div_cnt + DW'(1);
   end

   // receiver
   rx_state_t            rx_state, rx_next;
   logic                 rx_s1, rx_s2, rx_prev;
   logic [3:0]           rx_cnt;
   logic [3:0]           rx_bit_idx;
   logic                 rx_lead;
   logic                 smp7, smp8;
   logic [DATA_BITS-1:0] rx_shreg;
   logic                 rx_perr_q;
   logic                 rx_maj, rx_bit_dec, rx_exp_par;
   logic                 rx_push, rx_full, rx_empty;
   logic [DATA_BITS+1:0] rx_head;

   assign rx_maj     = (smp7 & smp8) | (smp7 & rx_s2) | (smp8 & rx_s2);
   // rx_lead masks the tail of the start bit that follows the tick-8 check
   assign rx_bit_dec = tick && (rx_cnt == 4'd9) && !rx_lead;
   assign rx_exp_par = (PARITY == 2) ? ~^rx_shreg : ^rx_shreg;

   always_comb begin
      rx_next = rx_state;
      rx_push = 1'b0;
      case (rx_state)
         RX_IDLE:  if (rx_prev && !rx_s2) rx_next = RX_START;
         RX_START: if (tick && rx_cnt == 4'd8) rx_next = rx_s2 ? RX_IDLE : RX_DATA;
         RX_DATA:  if (rx_bit_dec && rx_bit_idx == 4'(DATA_BITS - 1))
                      rx_next = (PARITY != 0) ? RX_PAR : RX_STOP;
         RX_PAR:   if (rx_bit_dec) rx_next = RX_STOP;
         RX_STOP:  if (rx_bit_dec) begin
                      rx_next = RX_IDLE;
                      rx_push = 1'b1;
                   end
         default:  rx_next = RX_IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         rx_state   <= RX_IDLE;
         rx_s1      <= 1'b1;
         rx_s2      <= 1'b1;
         rx_prev    <= 1'b1;
         rx_cnt     <= '0;
         rx_bit_idx <= '0;
         rx_lead    <= 1'b0;
         smp7       <= 1'b1;
         smp8       <= 1'b1;
         rx_shreg   <= '0;
         rx_perr_q  <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         rx_s1    <= Rx;
         rx_s2    <= rx_s1;
         rx_prev  <= rx_s2;
         rx_state <= rx_next;

         if (rx_state == RX_IDLE) rx_cnt <= '0;
         else if (tick)           rx_cnt <= rx_cnt + 4'd1;

         if (rx_state == RX_IDLE)
            rx_lead <= 1'b0;
         else if (rx_state == RX_START && tick && rx_cnt == 4'd8 && !rx_s2)
            rx_lead <= 1'b1;
         else if (tick && rx_cnt == 4'd15)
            rx_lead <= 1'b0;

         if (tick && rx_cnt == 4'd7) smp7 <= rx_s2;
         if (tick && rx_cnt == 4'd8) smp8 <= rx_s2;

         if (rx_state == RX_IDLE) begin
            rx_bit_idx <= '0;
            rx_perr_q  <= 1'b0;
         end else if (rx_state == RX_DATA && rx_bit_dec) begin
            rx_bit_idx <= rx_bit_idx + 4'd1;
            rx_shreg   <= {rx_maj, rx_shreg[DATA_BITS-1:1]};
         end else if (rx_state == RX_PAR && rx_bit_dec) begin
            rx_perr_q  <= rx_maj ^ rx_exp_par;
         end

         if (rx_push && rx_full) overrun <= 1'b1;
         else if (ovr_clr)       overrun <= 1'b0;
      end
   end

   uart_fifo #(.W(DATA_BITS + 2), .AW(FIFO_AW)) u_rx_fifo (
      .CLK       (CLK),
      .RST       (RST),
      .push      (rx_push),
      .push_data ({~rx_maj, rx_perr_q, rx_shreg}),
      .pop       (rx_ready),
      .head      (rx_head),
      .full      (rx_full),
      .empty     (rx_empty)
   );

   assign rx_valid = !rx_empty;
   assign rx_data  = rx_head[DATA_BITS-1:0];
   assign rx_perr  = rx_head[DATA_BITS];
   assign rx_ferr  = rx_head[DATA_BITS+1];

   // transmitter
   tx_state_t            tx_state, tx_next;
   logic [3:0]           tx_tcnt;
   logic                 baud;
   logic                 tx_pop, tx_full, tx_empty;
   logic [DATA_BITS-1:0] tx_head;
   logic                 tx_par;
   logic [FW-1:0]        tx_frame;
   logic [FW-2:0]        tx_sh;
   logic [3:0]           tx_left;
   logic                 tx_line;

   assign baud   = tick && (tx_tcnt == 4'd15);
   assign tx_par = (PARITY == 2) ? ~^tx_head : ^tx_head;

   always_comb begin
      tx_frame              = '1;
      tx_frame[0]           = 1'b0;
      tx_frame[DATA_BITS:1] = tx_head;
      if (PARITY != 0) tx_frame[DATA_BITS+1] = tx_par;
   end

   always_comb begin
      tx_next = tx_state;
      tx_pop  = 1'b0;
      case (tx_state)
         TX_IDLE: if (baud && !tx_empty) begin
                     tx_pop  = 1'b1;
                     tx_next = TX_SEND;
                  end
         TX_SEND: if (baud && tx_left == 4'd0) begin
                     if (!tx_empty) tx_pop  = 1'b1;
                     else           tx_next = TX_IDLE;
                  end
         default: tx_next = TX_IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         tx_state <= TX_IDLE;
         tx_tcnt  <= '0;
         tx_line  <= 1'b1;
         tx_sh    <= '1;
         tx_left  <= '0;
      end else begin
         tx_state <= tx_next;
         if (tick) tx_tcnt <= tx_tcnt + 4'd1;
         if (tx_pop) begin
            tx_line <= 1'b0;
            tx_sh   <= tx_frame[FW-1:1];
            tx_left <= 4'(FW - 1);
         end else if (tx_state == TX_SEND && baud) begin
            if (tx_left != 4'd0) begin
               tx_line <= tx_sh[0];
               tx_sh   <= {1'b1, tx_sh[FW-2:1]};
               tx_left <= tx_left - 4'd1;
            end else begin
               tx_line <= 1'b1;
            end
         end
      end
   end

   uart_fifo #(.W(DATA_BITS), .AW(FIFO_AW)) u_tx_fifo (
      .CLK       (CLK),
      .RST       (RST),
      .push      (tx_valid),
      .push_data (tx_data),
      .pop       (tx_pop),
      .head      (tx_head),
      .full      (tx_full),
      .empty     (tx_empty)
   );

   assign tx_ready = !tx_full;
   assign tx_busy  = (tx_state == TX_SEND);
   assign Tx       = tx_line;
endmodule
